// File: rtl/pj_pkg.sv
// Shared constants and types for the MindFocus game controller and its datapath.
// The state encoding here is what db_estado exposes.
package pj_pkg;

    localparam int TIMEOUT_DEFAULT = 50_000_000;
    localparam int NUM_RODADAS     = 3;

    typedef enum logic [3:0] {
        ST_INICIAL = 4'h0,
        ST_PREPARA = 4'h1,
        ST_GERA    = 4'h2,
        ST_REG_IND = 4'h3,
        ST_ESPERA  = 4'h4,
        ST_REG_JOG = 4'h5,
        ST_COMPARA = 4'h6,
        ST_ACERTO  = 4'h7,
        ST_TEMPO   = 4'h8,
        ST_PROX    = 4'h9,
        ST_CHECA   = 4'hA,
        ST_FIM     = 4'hB
    } estado_t;

    typedef struct packed {
        logic zera_a;
        logic zera_rod;
        logic zera_r;
        logic zera_m;
        logic zera_i;
        logic registra_r;
        logic registra_m;
        logic conta_a;
        logic conta_rod;
        logic conta_i;
        logic pronto;
        logic timeout;
    } saidas_t;

    localparam saidas_t SAIDAS_NENHUMA = '0;

    // Moore output table: one entry per state, everything else stays low.
    function automatic saidas_t decodifica_saidas(input estado_t e);
        saidas_t s;
        s = SAIDAS_NENHUMA;
        case (e)
            ST_PREPARA: begin
                s.zera_a   = 1'b1;
                s.zera_rod = 1'b1;
                s.zera_r   = 1'b1;
                s.zera_m   = 1'b1;
                s.zera_i   = 1'b1;
            end
            ST_GERA:    s.conta_i = 1'b1;
            ST_REG_IND: begin
                s.registra_m = 1'b1;
                s.zera_i     = 1'b1;
            end
            ST_ESPERA:  s.conta_i    = 1'b1;
            ST_REG_JOG: s.registra_r = 1'b1;
            ST_ACERTO:  s.conta_a    = 1'b1;
            ST_TEMPO:   s.timeout    = 1'b1;
            ST_PROX:    s.conta_rod  = 1'b1;
            ST_FIM:     s.pronto     = 1'b1;
            default:    s = SAIDAS_NENHUMA;
        endcase
        return s;
    endfunction

endpackage

// File: rtl/contador_m.sv
// Modulo-M up counter used as the play-window timer; saturates at M-1 so it
// never wraps while the controller is still deciding to leave the window.
module contador_m #(
    parameter int M = 8,
    parameter int N = (M > 1) ? $clog2(M) : 1
) (
    input  logic clock,
    input  logic reset,
    input  logic zera_as,
    input  logic conta,
    output logic fim
);

    localparam logic [N-1:0] MAXIMO = N'(M - 1);

    logic [N-1:0] r_q;

    // zera_as is a registered strobe from the controller, so it is glitch-free.
    always_ff @(posedge clock or negedge reset or posedge zera_as) begin
        if (!reset) begin
            r_q <= '0;
        end else if (zera_as) begin
            r_q <= '0;
        end else if (conta && (r_q != MAXIMO)) begin
            r_q <= r_q + N'(1);
        end
    end

    assign fim = (r_q == MAXIMO);

endmodule

// File: rtl/unidade_controle_jogo.sv
// Moore controller sequencing the MindFocus datapath: index fetch, timed play
// window, scoring and round advance. All outputs are registered state decodes.
module unidade_controle_jogo
    import pj_pkg::*;
#(
    parameter int TIMEOUT = TIMEOUT_DEFAULT
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       iniciar,
    input  logic       indice_pronto,
    input  logic       jogada_feita,
    input  logic       botaoIgualMemoria,
    input  logic       rodadaIgualFinal,
    output logic       zeraA,
    output logic       zeraRod,
    output logic       zeraR,
    output logic       zeraM,
    output logic       zeraI,
    output logic       registraR,
    output logic       registraM,
    output logic       contaA,
    output logic       contaRod,
    output logic       contaI,
    output logic       pronto,
    output logic       db_timeout,
    output logic [3:0] db_estado
);

    estado_t r_estado;
    estado_t w_prox;
    saidas_t r_saidas;
    logic    r_timer_zera;
    logic    r_timer_conta;
    logic    w_timer_fim;

    contador_m #(
        .M (TIMEOUT)
    ) u_timer (
        .clock   (clock),
        .reset   (reset),
        .zera_as (r_timer_zera),
        .conta   (r_timer_conta),
        .fim     (w_timer_fim)
    );

    // A move in the last window cycle beats the timeout.
    always_comb begin
        w_prox = ST_INICIAL;
        case (r_estado)
            ST_INICIAL: w_prox = iniciar ? ST_PREPARA : ST_INICIAL;
            ST_PREPARA: w_prox = ST_GERA;
            ST_GERA:    w_prox = indice_pronto ? ST_REG_IND : ST_GERA;
            ST_REG_IND: w_prox = ST_ESPERA;
            ST_ESPERA: begin
                if (jogada_feita) begin
                    w_prox = ST_REG_JOG;
                end else if (w_timer_fim) begin
                    w_prox = ST_TEMPO;
                end else begin
                    w_prox = ST_ESPERA;
                end
            end
            ST_REG_JOG: w_prox = ST_COMPARA;
            ST_COMPARA: w_prox = botaoIgualMemoria ? ST_ACERTO : ST_PROX;
            ST_ACERTO:  w_prox = ST_PROX;
            ST_TEMPO:   w_prox = ST_PROX;
            ST_PROX:    w_prox = ST_CHECA;
            ST_CHECA:   w_prox = rodadaIgualFinal ? ST_FIM : ST_GERA;
            ST_FIM:     w_prox = iniciar ? ST_PREPARA : ST_FIM;
            default:    w_prox = ST_INICIAL;
        endcase
    end

    // Outputs are decoded from the next state so they line up with r_estado.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_estado      <= ST_INICIAL;
            r_saidas      <= SAIDAS_NENHUMA;
            r_timer_zera  <= 1'b0;
            r_timer_conta <= 1'b0;
        end else begin
            r_estado      <= w_prox;
            r_saidas      <= decodifica_saidas(w_prox);
            r_timer_zera  <= (w_prox == ST_REG_IND);
            r_timer_conta <= (w_prox == ST_ESPERA);
        end
    end

    assign zeraA      = r_saidas.zera_a;
    assign zeraRod    = r_saidas.zera_rod;
    assign zeraR      = r_saidas.zera_r;
    assign zeraM      = r_saidas.zera_m;
    assign zeraI      = r_saidas.zera_i;
    assign registraR  = r_saidas.registra_r;
    assign registraM  = r_saidas.registra_m;
    assign contaA     = r_saidas.conta_a;
    assign contaRod   = r_saidas.conta_rod;
    assign contaI     = r_saidas.conta_i;
    assign pronto     = r_saidas.pronto;
    assign db_timeout = r_saidas.timeout;
    assign db_estado  = r_estado;

endmodule

// File: tb/tb_unidade_controle_jogo.sv
// Randomized bench for unidade_controle_jogo: a round-level model expands each
// game into its expected per-cycle trace, and a monitor checks the DUT against it.
module tb_unidade_controle_jogo;

    localparam int TO = 8;

    localparam int S_INICIAL = 0;
    localparam int S_PREPARA = 1;
    localparam int S_GERA    = 2;
    localparam int S_REG_IND = 3;
    localparam int S_ESPERA  = 4;
    localparam int S_REG_JOG = 5;
    localparam int S_COMPARA = 6;
    localparam int S_ACERTO  = 7;
    localparam int S_TEMPO   = 8;
    localparam int S_PROX    = 9;
    localparam int S_CHECA   = 10;
    localparam int S_FIM     = 11;

    logic       clock             = 1'b0;
    logic       reset             = 1'b0;
    logic       iniciar           = 1'b0;
    logic       indice_pronto     = 1'b0;
    logic       jogada_feita      = 1'b0;
    logic       botaoIgualMemoria = 1'b0;
    logic       rodadaIgualFinal  = 1'b0;
    logic       zeraA, zeraRod, zeraR, zeraM, zeraI;
    logic       registraR, registraM;
    logic       contaA, contaRod, contaI;
    logic       pronto, db_timeout;
    logic [3:0] db_estado;

    int          n_vec = 0;
    int          n_err = 0;
    logic [15:0] exp_q[$];
    logic [15:0] mon_exp;
    logic [15:0] mon_act;

    unidade_controle_jogo #(
        .TIMEOUT (TO)
    ) dut (
        .clock             (clock),
        .reset             (reset),
        .iniciar           (iniciar),
        .indice_pronto     (indice_pronto),
        .jogada_feita      (jogada_feita),
        .botaoIgualMemoria (botaoIgualMemoria),
        .rodadaIgualFinal  (rodadaIgualFinal),
        .zeraA             (zeraA),
        .zeraRod           (zeraRod),
        .zeraR             (zeraR),
        .zeraM             (zeraM),
        .zeraI             (zeraI),
        .registraR         (registraR),
        .registraM         (registraM),
        .contaA            (contaA),
        .contaRod          (contaRod),
        .contaI            (contaI),
        .pronto            (pronto),
        .db_timeout        (db_timeout),
        .db_estado         (db_estado)
    );

    always #5 clock = ~clock;

    // Expected word {state, zeraA..db_timeout} straight from the state table.
    function automatic logic [15:0] exp_word(input int st);
        logic [11:0] o;
        o = '0;
        case (st)
            S_PREPARA: o[11:7] = 5'b11111;
            S_GERA:    o[2]    = 1'b1;
            S_REG_IND: begin o[5] = 1'b1; o[7] = 1'b1; end
            S_ESPERA:  o[2]    = 1'b1;
            S_REG_JOG: o[6]    = 1'b1;
            S_ACERTO:  o[4]    = 1'b1;
            S_TEMPO:   o[0]    = 1'b1;
            S_PROX:    o[3]    = 1'b1;
            S_FIM:     o[1]    = 1'b1;
            default:   o       = '0;
        endcase
        return {4'(st), o};
    endfunction

    function automatic logic [15:0] act_word();
        return {db_estado, zeraA, zeraRod, zeraR, zeraM, zeraI, registraR,
                registraM, contaA, contaRod, contaI, pronto, db_timeout};
    endfunction

    task automatic check_word(input string nome, input logic [15:0] act, input logic [15:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s @%0t: got estado=%h outs=%b, want estado=%h outs=%b",
                     nome, $time, act[15:12], act[11:0], exp[15:12], exp[11:0]);
        end
    endtask

    // Monitor: every sampled cycle with a pending expectation is compared.
    always @(negedge clock) begin
        if (exp_q.size() > 0) begin
            mon_exp = exp_q.pop_front();
            mon_act = act_word();
            check_word("trace", mon_act, mon_exp);
        end
    end

    // One clock: the state expected after this edge is queued for the monitor.
    task automatic cyc(input int st);
        @(posedge clock);
        exp_q.push_back(exp_word(st));
        #1;
    endtask

    task automatic noise();
        indice_pronto     = 1'($urandom_range(0, 1));
        jogada_feita      = 1'($urandom_range(0, 1));
        botaoIgualMemoria = 1'($urandom_range(0, 1));
        rodadaIgualFinal  = 1'($urandom_range(0, 1));
        iniciar           = 1'($urandom_range(0, 1));
    endtask

    // One round: g GERA cycles, move in ESPERA cycle k (0 = none),
    // optional asynchronous reset in ESPERA cycle rst_c.
    task automatic do_round(input int g, input int k, input bit igual, input bit last,
                            input int rst_c, output bit abortado);
        bit hit;
        abortado = 1'b0;
        hit      = 1'b0;
        cyc(S_GERA);
        for (int i = 1; i <= g; i++) begin
            noise();
            indice_pronto = (i == g);
            if (i < g) cyc(S_GERA);
        end
        cyc(S_REG_IND);
        noise();
        cyc(S_ESPERA);
        for (int c = 1; c <= TO; c++) begin
            noise();
            jogada_feita = (c == k);
            if (c == rst_c) begin
                jogada_feita = 1'b0;
                #5;
                reset = 1'b0;
                #1;
                check_word("reset_async", act_word(), 16'h0000);
                abortado = 1'b1;
                return;
            end
            if (c == k) begin
                cyc(S_REG_JOG);
                hit = 1'b1;
                break;
            end
            if (c == TO) cyc(S_TEMPO);
            else cyc(S_ESPERA);
        end
        noise();
        if (hit) begin
            cyc(S_COMPARA);
            noise();
            botaoIgualMemoria = igual;
            if (igual) begin
                cyc(S_ACERTO);
                noise();
            end
        end
        cyc(S_PROX);
        noise();
        cyc(S_CHECA);
        noise();
        rodadaIgualFinal = last;
        if (last) cyc(S_FIM);
    endtask

    task automatic play_game(input bit directed, input int rst_round, output bit abortado);
        int dg[3];
        int dk[3];
        bit di[3];
        int nr;
        int g, k, rc;
        bit ig;
        dg = '{5, 1, 1};
        dk = '{2, 0, TO};
        di = '{1'b1, 1'b0, 1'b0};
        abortado = 1'b0;
        nr = directed ? 3 : $urandom_range(1, 4);
        iniciar = 1'b1;
        cyc(S_PREPARA);
        noise();
        for (int r = 0; r < nr; r++) begin
            if (directed) begin
                g = dg[r]; k = dk[r]; ig = di[r];
            end else begin
                g  = $urandom_range(1, 4);
                k  = $urandom_range(0, TO);
                ig = 1'($urandom_range(0, 1));
            end
            rc = -1;
            if (r == rst_round) begin
                k  = 0;
                rc = $urandom_range(1, TO);
            end
            do_round(g, k, ig, (r == nr - 1), rc, abortado);
            if (abortado) return;
        end
        iniciar = 1'b0;
        repeat ($urandom_range(1, 3)) cyc(S_FIM);
    endtask

    task automatic hold_inicial(input int n);
        repeat (n) begin
            noise();
            iniciar = 1'b0;
            cyc(S_INICIAL);
        end
    endtask

    initial begin
        bit ab;
        reset = 1'b0;
        hold_inicial(2);
        reset = 1'b1;
        hold_inicial(3);
        play_game(1'b1, -1, ab);
        play_game(1'b0, 1, ab);
        hold_inicial(2);
        reset = 1'b1;
        hold_inicial(4);
        for (int n = 0; n < 8; n++) play_game(1'b0, -1, ab);
        for (int w = 0; w < 5 && exp_q.size() > 0; w++) @(negedge clock);
        #1;
        n_vec++;
        if (exp_q.size() != 0) begin
            n_err++;
            $display("FAIL drain: %0d expectations left, want 0", exp_q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

endmodule
